// File: rtl/sent_tx_control_if.sv
// Frame handoff between the SENT TX frame builder and the TX pulse generator.
// The builder (master) presents a complete 32-bit frame with frame_valid and
// holds it until the pulse generator (slave) returns frame_ready.
interface sent_tx_control_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] frame_nibbles;

  modport master (
    output frame_valid,
    output frame_nibbles,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_nibbles,
    output frame_ready
  );
endinterface

// File: rtl/sent_tx_control.sv
// SENT transmit frame builder.
// Pops one or two fast-channel words from the TX FIFO and packs them into six
// data nibbles according to the latched frame format. It computes the
// fast-channel CRC-4 nibble-serially and inserts the 16-frame short serial
// message into status bits 3:2. Each completed frame is handed to the pulse
// generator over a valid/ready handshake.
module sent_tx_control (
  input  logic                      clk_tx,
  input  logic                      reset_n_tx,
  input  logic                      enable_tx,
  input  logic [2:0]                frame_format,
  input  logic                      fifo_empty_tx,
  output logic                      read_enable_tx,
  input  logic [15:0]               data_fifo_tx,
  input  logic [1:0]                status_bits,
  input  logic [3:0]                serial_id,
  input  logic [7:0]                serial_data,
  sent_tx_control_if.master         frame_if,
  output logic                      tx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_POP2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_PACK  = 3'd5,
    ST_CRC   = 3'd6,
    ST_VALID = 3'd7
  } state_t;

  // One nibble of the SENT CRC-4 (x^4+x^3+x^2+1), bits taken MSB-first.
  function automatic logic [3:0] f_crc4_nibble(input logic [3:0] crc_in,
                                               input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
    end
    return c;
  endfunction

  // Formats carrying two fast-channel words need a second FIFO pop.
  function automatic logic f_two_word(input logic [2:0] fmt);
    return (fmt == 3'd1) || (fmt == 3'd6) || (fmt == 3'd7);
  endfunction

  // Six-nibble payload, D1 in [23:20] down to D6 in [3:0].
  function automatic logic [23:0] f_payload(input logic [2:0]  fmt,
                                            input logic [15:0] ch1,
                                            input logic [11:0] ch2,
                                            input logic [7:0]  cnt);
    logic [23:0] p;
    case (fmt)
      3'd1:             p = {ch1[11:0], ch2[3:0], ch2[7:4], ch2[11:8]};
      3'd2, 3'd3, 3'd5: p = {ch1[11:0], 12'h000};
      3'd4:             p = {ch1[11:0], cnt, ~ch1[11:8]};
      3'd6:             p = {ch1[13:0], ch2[9:0]};
      3'd7:             p = {ch1[15:0], ch2[7:0]};
      default:          p = 24'h000000;
    endcase
    return p;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic        w_read_enable;
  logic [2:0]  r_fmt;
  logic [15:0] r_ch1;
  logic [11:0] r_ch2;
  logic [23:0] r_payload;
  logic [23:0] r_shift;
  logic [3:0]  r_crc;
  logic [3:0]  r_scrc;
  logic [2:0]  r_crc_cnt;
  logic [15:0] r_msg;
  logic [3:0]  r_frame_idx;
  logic [7:0]  r_cnt;
  logic        r_frame_valid;
  logic [31:0] r_frame_nibbles;
  logic        r_tx_busy;
  logic [3:0]  w_fast_crc;
  logic [3:0]  w_serial_nib;
  logic [3:0]  w_serial_crc;
  logic        w_msg_bit;

  assign read_enable_tx         = w_read_enable;
  assign frame_if.frame_valid   = r_frame_valid;
  assign frame_if.frame_nibbles = r_frame_nibbles;
  assign tx_busy                = r_tx_busy;

  assign w_fast_crc   = f_crc4_nibble(r_crc, r_shift[23:20]);
  assign w_serial_crc = f_crc4_nibble(r_scrc, w_serial_nib);
  assign w_msg_bit    = r_msg[4'd15 - r_frame_idx];

  // Serial-message nibble fed to the serial CRC on each of the first four CRC cycles.
  always_comb begin
    w_serial_nib = 4'h0;
    case (r_crc_cnt)
      3'd0:    w_serial_nib = r_msg[15:12];
      3'd1:    w_serial_nib = r_msg[11:8];
      3'd2:    w_serial_nib = r_msg[7:4];
      default: w_serial_nib = 4'h0;
    endcase
  end

  // Next-state and pop strobe; a pop is only issued when the FIFO has data.
  always_comb begin
    w_next_state  = r_state;
    w_read_enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_tx && (frame_format != 3'd0)) w_next_state = ST_POP1;
        else                                     w_next_state = ST_IDLE;
      end
      ST_POP1: begin
        if (!fifo_empty_tx) begin
          w_read_enable = 1'b1;
          w_next_state  = ST_WAIT1;
        end else begin
          w_next_state  = ST_POP1;
        end
      end
      ST_WAIT1: begin
        if (f_two_word(r_fmt)) w_next_state = ST_POP2;
        else                   w_next_state = ST_PACK;
      end
      ST_POP2: begin
        if (!fifo_empty_tx) begin
          w_read_enable = 1'b1;
          w_next_state  = ST_WAIT2;
        end else begin
          w_next_state  = ST_POP2;
        end
      end
      ST_WAIT2: w_next_state = ST_PACK;
      ST_PACK:  w_next_state = ST_CRC;
      ST_CRC: begin
        if (r_crc_cnt == 3'd6) w_next_state = ST_VALID;
        else                   w_next_state = ST_CRC;
      end
      ST_VALID: begin
        if (frame_if.frame_ready) begin
          if (enable_tx) w_next_state = ST_POP1;
          else           w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_VALID;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks "not IDLE".
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      r_state   <= ST_IDLE;
      r_tx_busy <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tx_busy <= (w_next_state != ST_IDLE);
    end
  end

  // Frame datapath: word capture, packing, CRCs, serial message and handoff.
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      r_fmt           <= 3'd0;
      r_ch1           <= 16'h0000;
      r_ch2           <= 12'h000;
      r_payload       <= 24'h000000;
      r_shift         <= 24'h000000;
      r_crc           <= 4'h0;
      r_scrc          <= 4'h0;
      r_crc_cnt       <= 3'd0;
      r_msg           <= 16'h0000;
      r_frame_idx     <= 4'd0;
      r_cnt           <= 8'd0;
      r_frame_valid   <= 1'b0;
      r_frame_nibbles <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_next_state == ST_POP1) r_fmt <= frame_format;
        end
        ST_WAIT1: r_ch1 <= data_fifo_tx;
        ST_WAIT2: r_ch2 <= data_fifo_tx[11:0];
        ST_PACK: begin
          r_payload <= f_payload(r_fmt, r_ch1, r_ch2, r_cnt);
          r_shift   <= f_payload(r_fmt, r_ch1, r_ch2, r_cnt);
          r_crc     <= 4'b0101;
          r_scrc    <= 4'b0101;
          r_crc_cnt <= 3'd0;
          if (r_frame_idx == 4'd0) r_msg <= {serial_id, serial_data, 4'h0};
        end
        ST_CRC: begin
          // After six shifts the register is zero, which supplies the augmentation nibble.
          r_crc     <= w_fast_crc;
          r_shift   <= {r_shift[19:0], 4'h0};
          r_crc_cnt <= r_crc_cnt + 3'd1;
          if ((r_frame_idx == 4'd0) && (r_crc_cnt < 3'd4)) begin
            r_scrc <= w_serial_crc;
            if (r_crc_cnt == 3'd3) r_msg[3:0] <= w_serial_crc;
          end
          if (r_crc_cnt == 3'd6) begin
            r_frame_valid   <= 1'b1;
            r_frame_nibbles <= {(r_frame_idx == 4'd0), w_msg_bit, status_bits,
                                r_payload, w_fast_crc};
          end
        end
        ST_VALID: begin
          if (frame_if.frame_ready) begin
            r_frame_valid <= 1'b0;
            r_frame_idx   <= r_frame_idx + 4'd1;
            r_cnt         <= r_cnt + 8'd1;
          end
        end
        default: r_crc_cnt <= r_crc_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_control.sv
// Scoreboard testbench for sent_tx_control: stimulus pushes expected frames,
// a negedge monitor pops and compares them as frames appear.
module tb_sent_tx_control;
  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic        enable_tx;
  logic [2:0]  frame_format;
  logic        fifo_empty_tx;
  logic        read_enable_tx;
  logic [15:0] data_fifo_tx;
  logic [1:0]  status_bits;
  logic [3:0]  serial_id;
  logic [7:0]  serial_data;
  logic        tx_busy;

  sent_tx_control_if fif ();

  sent_tx_control dut (
    .clk_tx        (clk_tx),
    .reset_n_tx    (reset_n_tx),
    .enable_tx     (enable_tx),
    .frame_format  (frame_format),
    .fifo_empty_tx (fifo_empty_tx),
    .read_enable_tx(read_enable_tx),
    .data_fifo_tx  (data_fifo_tx),
    .status_bits   (status_bits),
    .serial_id     (serial_id),
    .serial_data   (serial_data),
    .frame_if      (fif.master),
    .tx_busy       (tx_busy)
  );

  always #5 clk_tx = ~clk_tx;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pops = 0;
  int          gap = 0;
  bit          gap_arm = 0;
  int          hs_count = 0;
  int          t_start = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] fifo_q[$];
  logic [3:0]  m_idx = 4'd0;
  logic [15:0] m_msg = 16'h0000;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_busy = 1'b0;
  logic [31:0] held = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC: seed 0101, bit-serial over the top nbits of the vector.
  function automatic logic [3:0] ref_crc(input logic [27:0] bits, input int nbits);
    logic [3:0] c;
    logic       fb;
    c = 4'b0101;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[3] ^ bits[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ 4'b1101;
    end
    return c;
  endfunction

  task automatic push_raw(input logic [31:0] word, input int lat);
    exp_q.push_back(word);
    lat_q.push_back(lat);
    m_idx = m_idx + 4'd1;
  endtask

  task automatic push_frame(input logic [23:0] payload, input int lat);
    logic [3:0] st;
    if (m_idx == 4'd0)
      m_msg = {serial_id, serial_data, ref_crc({12'h000, serial_id, serial_data, 4'h0}, 16)};
    st = {(m_idx == 4'd0), m_msg[4'd15 - m_idx], status_bits};
    push_raw({st, payload, ref_crc({payload, 4'h0}, 28)}, lat);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while ((hs_count < target) && (n < budget)) begin
      @(negedge clk_tx);
      n++;
    end
    if (hs_count < target) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: got %0d handshakes expected %0d", hs_count, target);
    end
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!tx_busy && (n < budget)) begin
      @(negedge clk_tx);
      n++;
    end
    if (!tx_busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy && (n < budget)) begin
      @(negedge clk_tx);
      n++;
    end
    chk("idle_timeout", tx_busy, 1'b0);
  endtask

  task automatic run_frames(input int n);
    int base;
    base = hs_count;
    repeat (2) @(posedge clk_tx);
    #1 enable_tx = 1'b1;
    if (n > 1) wait_hs(base + n - 1, 40 * n);
    else       wait_busy(20);
    @(posedge clk_tx);
    #1 enable_tx = 1'b0;
    wait_hs(base + n, 100);
    wait_idle(20);
  endtask

  task automatic do_reset();
    @(posedge clk_tx);
    #1;
    reset_n_tx = 1'b0;
    enable_tx  = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    lat_q.delete();
    gap     = 0;
    gap_arm = 0;
    m_idx   = 4'd0;
    m_msg   = 16'h0000;
    @(negedge clk_tx);
    chk("rst_read_enable", read_enable_tx, 1'b0);
    chk("rst_frame_valid", fif.frame_valid, 1'b0);
    chk("rst_frame_nibbles", fif.frame_nibbles, 32'h0);
    chk("rst_tx_busy", tx_busy, 1'b0);
    repeat (2) @(posedge clk_tx);
    #1 reset_n_tx = 1'b1;
  endtask

  // Cycle counter for latency measurement.
  initial forever @(posedge clk_tx) cyc++;

  // FIFO model: data appears after a pop; optional empty gap after an armed pop.
  initial begin
    fifo_empty_tx = 1'b1;
    data_fifo_tx  = 16'h0000;
    forever begin
      @(negedge clk_tx);
      if (read_enable_tx) begin
        chk("pop_while_empty", fifo_empty_tx, 1'b0);
        pops++;
        if (fifo_q.size() > 0) data_fifo_tx = fifo_q.pop_front();
        if (gap_arm) begin
          gap     = 6;
          gap_arm = 0;
        end
      end
      @(posedge clk_tx);
      #1;
      if (gap > 0) begin
        fifo_empty_tx = 1'b1;
        gap--;
      end else begin
        fifo_empty_tx = (fifo_q.size() == 0);
      end
    end
  end

  // Monitor: compares each new frame against the scoreboard and checks handshake timing.
  initial forever begin
    @(negedge clk_tx);
    if (!reset_n_tx) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (tx_busy && !prev_busy) t_start = cyc;
      if (prev_hs) chk("valid_fall", fif.frame_valid, 1'b0);
      if (fif.frame_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h expected none", fif.frame_nibbles);
        end else begin
          logic [31:0] e;
          int          l;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          chk("frame", fif.frame_nibbles, e);
          if (l >= 0) chk("latency", cyc - t_start, l);
        end
        held = fif.frame_nibbles;
      end else if (fif.frame_valid) begin
        chk("frame_stable", fif.frame_nibbles, held);
      end
      prev_hs = fif.frame_valid && fif.frame_ready;
      if (prev_hs) hs_count++;
      prev_valid = fif.frame_valid;
      prev_busy  = tx_busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n_tx      = 1'b0;
    enable_tx       = 1'b0;
    frame_format    = 3'd0;
    status_bits     = 2'b00;
    serial_id       = 4'h0;
    serial_data     = 8'h00;
    fif.frame_ready = 1'b1;
    do_reset();

    // Format 2, zero word, pulse generator stalls for three cycles.
    frame_format    = 3'd2;
    fifo_q.push_back(16'h0000);
    push_raw(32'h8000_0005, 10);
    p0 = pops;
    fif.frame_ready = 1'b0;
    repeat (2) @(posedge clk_tx);
    #1 enable_tx = 1'b1;
    wait_busy(20);
    @(posedge clk_tx);
    #1 enable_tx = 1'b0;
    for (int i = 0; (i < 30) && !fif.frame_valid; i++) @(negedge clk_tx);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_tx);
      chk("valid_held", fif.frame_valid, 1'b1);
    end
    @(posedge clk_tx);
    #1 fif.frame_ready = 1'b1;
    wait_hs(1, 20);
    wait_idle(20);
    chk("pops_fmt2", pops - p0, 1);

    // Format 1, two words, D1..D6 = A,B,C,3,2,1.
    frame_format = 3'd1;
    status_bits  = 2'b10;
    fifo_q.push_back(16'h0ABC);
    fifo_q.push_back(16'h0123);
    push_frame(24'hABC321, 12);
    p0 = pops;
    run_frames(1);
    chk("pops_fmt1", pops - p0, 2);

    // Format 7 with the FIFO empty for five POP2 cycles.
    frame_format = 3'd7;
    status_bits  = 2'b01;
    fifo_q.push_back(16'hBEEF);
    fifo_q.push_back(16'h1234);
    push_frame(24'hBEEF34, 17);
    gap_arm = 1;
    p0 = pops;
    run_frames(1);
    chk("pops_fmt7", pops - p0, 2);

    // Format 4, three frames back-to-back; rolling counter in D4D5.
    do_reset();
    frame_format = 3'd4;
    status_bits  = 2'b11;
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'h0A50);
    push_frame(24'hA50005, 10);
    push_frame(24'hA50015, -1);
    push_frame(24'hA50025, -1);
    run_frames(3);

    // Seventeen frames: full serial message cycle and frame_idx wrap.
    do_reset();
    frame_format = 3'd2;
    status_bits  = 2'b00;
    serial_id    = 4'h3;
    serial_data  = 8'hC5;
    for (int i = 0; i < 17; i++) begin
      logic [15:0] w;
      w = 16'h0100 + 16'(i * 17);
      fifo_q.push_back(w);
      push_frame({w[11:0], 12'h000}, (i == 0) ? 10 : -1);
    end
    run_frames(17);

    // Reset in the middle of the CRC phase discards the frame; restart at idx 0, cnt 0.
    frame_format = 3'd4;
    fifo_q.push_back(16'h0A50);
    repeat (2) @(posedge clk_tx);
    #1 enable_tx = 1'b1;
    wait_busy(20);
    @(posedge clk_tx);
    #1 enable_tx = 1'b0;
    repeat (4) @(negedge clk_tx);
    do_reset();
    fifo_q.push_back(16'h0A50);
    push_frame(24'hA50005, 10);
    run_frames(1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
